regfile_bypass_sb: RTL
======================

Name: regfile_bypass_sb

Overview:
- Parametrised successor to the 32x32 single-write register file.
- Provides configurable width and depth, two read ports and two write ports with defined collision priority.
- Adds optional write-to-read bypass, a hardwired zero register, and a per-register pending-write scoreboard for the pipelined datapath.
- Sits between decode (read/issue) and writeback (two writeback lanes).

Parameters:
- WIDTH, 32, data width in bits (>=1).
- NREGS, 32, number of registers; power of two, >=2.
- SELW, 5, select width; must equal log2(NREGS).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never marked busy.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- rd_sel1  input  SELW  read port 1 select.
- rd_sel2  input  SELW  read port 2 select.
- rd_data1  output  WIDTH  read port 1 data, combinational.
- rd_data2  output  WIDTH  read port 2 data, combinational.
- rd_busy1  output  1  scoreboard bit of rd_sel1, combinational.
- rd_busy2  output  1  scoreboard bit of rd_sel2, combinational.
- wr_en0  input  1  write port 0 enable.
- wr_sel0  input  SELW  write port 0 select.
- wr_data0  input  WIDTH  write port 0 data.
- wr_en1  input  1  write port 1 enable (higher priority).
- wr_sel1  input  SELW  write port 1 select.
- wr_data1  input  WIDTH  write port 1 data.
- iss_en  input  1  mark destination register pending.
- iss_sel  input  SELW  destination register to mark.
- busy_any  output  1  OR of all scoreboard bits.

Behaviour:
- One clock domain; reset is synchronous and active-high on rst.

Reset:
- On a clk edge with rst=1, all registers are cleared to 0 and all busy bits to 0.
- wr_en*/iss_en are ignored in that cycle.
- After reset: rd_data*=0, rd_busy*=0, busy_any=0. This is also the required behaviour when rst asserts mid-operation.

Write:
- On a clk edge with rst=0, reg[wr_selN] <= wr_dataN when wr_enN=1.
- Both ports enabled with the same select: port 1 data is stored; port 0 is dropped.
- Different selects: both writes commit in the same edge.

Read (combinational, zero latency):
- rd_dataK = reg[rd_selK].
- If BYPASS=1 and a write is enabled to rd_selK this cycle, rd_dataK = that write's data. Port 1 has priority over port 0, matching the stored result.
- If BYPASS=0, the new value is visible only after the edge.

Zero register (ZERO_REG=1):
- Select 0 always reads 0 and rd_busy=0, including under bypass.
- Writes to 0 are discarded; iss_en with iss_sel=0 is ignored.
- ZERO_REG=0: register 0 behaves like any other register.

Scoreboard (one bit per register, updated per edge):
- iss_en=1 sets busy[iss_sel].
- A write via either port clears busy[wr_sel].
- Issue and write to the same register in the same cycle: busy stays 1 (the new producer wins).
- Issue to a register that is already busy: stays 1. No counting; a single outstanding producer per register is the contract.
- Write to a non-busy register: busy stays 0; data is still written.
- rd_busyK reflects the registered bit. With BYPASS=1, a write to rd_selK in the current cycle forces rd_busyK=0 unless iss_en targets the same register in that cycle.

Widths and sizing:
- Select values are always in range because NREGS = 2^SELW. No truncation or extension of data.

Test Plan:
- Reset, then read every register on both ports -> all rd_data=0, rd_busy=0, busy_any=0.
- Write reg5=0xDEADBEEF via port 0. BYPASS=1 and rd_sel1=5 in the same cycle -> rd_data1=0xDEADBEEF that cycle. BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next cycle.
- Both ports write reg7 (port 0: 0x11111111, port 1: 0x22222222) -> bypass read gives 0x22222222, and the stored value next cycle is 0x22222222. Simultaneous port 0 to reg3 and port 1 to reg4 -> both stored.
- Write reg0=0xFFFFFFFF with iss_en, iss_sel=0 (ZERO_REG=1) -> rd_data=0 and rd_busy=0 on both the same and the next cycle.
- Issue reg9 -> rd_busy=1 and busy_any=1 next cycle. Write reg9=0x00000042 -> same-cycle rd_busy=0 (bypass), busy bit cleared next cycle. Issue plus write reg9 in the same cycle -> busy=1 next cycle.
- Fill reg1..reg4 with data and set them busy, then assert rst mid-stream alongside wr_en1 to reg2 -> after the edge all data=0, all busy=0, and the reg2 write is lost.

Source files
------------

// File: rtl/regfile_bypass_sb_if.sv
// Register file bus: decode read/issue side plus two writeback lanes.
// The master drives selects, writes and issues; the slave is the regfile.
interface regfile_bypass_sb_if #(
    parameter int WIDTH = 32,
    parameter int SELW  = 5
);
    logic [SELW-1:0]  rd_sel1;
    logic [SELW-1:0]  rd_sel2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             rd_busy1;
    logic             rd_busy2;
    logic             wr_en0;
    logic [SELW-1:0]  wr_sel0;
    logic [WIDTH-1:0] wr_data0;
    logic             wr_en1;
    logic [SELW-1:0]  wr_sel1;
    logic [WIDTH-1:0] wr_data1;
    logic             iss_en;
    logic [SELW-1:0]  iss_sel;
    logic             busy_any;

    modport master (
        output rd_sel1, rd_sel2,
        output wr_en0, wr_sel0, wr_data0,
        output wr_en1, wr_sel1, wr_data1,
        output iss_en, iss_sel,
        input  rd_data1, rd_data2,
        input  rd_busy1, rd_busy2,
        input  busy_any
    );

    modport slave (
        input  rd_sel1, rd_sel2,
        input  wr_en0, wr_sel0, wr_data0,
        input  wr_en1, wr_sel1, wr_data1,
        input  iss_en, iss_sel,
        output rd_data1, rd_data2,
        output rd_busy1, rd_busy2,
        output busy_any
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Two-read/two-write register file with optional write bypass,
// hardwired zero register and a pending-write scoreboard.
module regfile_bypass_sb #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int SELW     = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic                clk,
    input logic                rst,
    regfile_bypass_sb_if.slave bus
);
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             we0;
    logic             we1;
    logic             iss;
    logic             hit0_1;
    logic             hit1_1;
    logic             hit0_2;
    logic             hit1_2;
    logic             iss_1;
    logic             iss_2;

    function automatic logic is_zero(input logic [SELW-1:0] sel);
        return (ZERO_REG != 0) && (sel == '0);
    endfunction

    // Writes and issues aimed at the zero register are dropped here,
    // so neither storage nor scoreboard ever sees them.
    assign we0 = bus.wr_en0 && !is_zero(bus.wr_sel0);
    assign we1 = bus.wr_en1 && !is_zero(bus.wr_sel1);
    assign iss = bus.iss_en && !is_zero(bus.iss_sel);

    assign hit0_1 = we0 && (bus.wr_sel0 == bus.rd_sel1);
    assign hit1_1 = we1 && (bus.wr_sel1 == bus.rd_sel1);
    assign hit0_2 = we0 && (bus.wr_sel0 == bus.rd_sel2);
    assign hit1_2 = we1 && (bus.wr_sel1 == bus.rd_sel2);
    assign iss_1  = iss && (bus.iss_sel == bus.rd_sel1);
    assign iss_2  = iss && (bus.iss_sel == bus.rd_sel2);

    // Read port 1: stored value, overridden by a same-cycle write (lane 1 first).
    always_comb begin
        bus.rd_data1 = regs_q[bus.rd_sel1];
        if (BYPASS != 0) begin
            if (hit1_1) begin
                bus.rd_data1 = bus.wr_data1;
            end else if (hit0_1) begin
                bus.rd_data1 = bus.wr_data0;
            end
        end
        if (is_zero(bus.rd_sel1)) begin
            bus.rd_data1 = '0;
        end
    end

    // Read port 2: same selection rules as port 1.
    always_comb begin
        bus.rd_data2 = regs_q[bus.rd_sel2];
        if (BYPASS != 0) begin
            if (hit1_2) begin
                bus.rd_data2 = bus.wr_data1;
            end else if (hit0_2) begin
                bus.rd_data2 = bus.wr_data0;
            end
        end
        if (is_zero(bus.rd_sel2)) begin
            bus.rd_data2 = '0;
        end
    end

    // Busy views: a landing write hides the bit unless a new producer issues.
    always_comb begin
        bus.rd_busy1 = busy_q[bus.rd_sel1];
        bus.rd_busy2 = busy_q[bus.rd_sel2];
        if ((BYPASS != 0) && (hit0_1 || hit1_1) && !iss_1) begin
            bus.rd_busy1 = 1'b0;
        end
        if ((BYPASS != 0) && (hit0_2 || hit1_2) && !iss_2) begin
            bus.rd_busy2 = 1'b0;
        end
        if (is_zero(bus.rd_sel1)) begin
            bus.rd_busy1 = 1'b0;
        end
        if (is_zero(bus.rd_sel2)) begin
            bus.rd_busy2 = 1'b0;
        end
    end

    // Scoreboard next state: writes retire producers, issue wins over retire.
    always_comb begin
        busy_d = busy_q;
        if (we0) begin
            busy_d[bus.wr_sel0] = 1'b0;
        end
        if (we1) begin
            busy_d[bus.wr_sel1] = 1'b0;
        end
        if (iss) begin
            busy_d[bus.iss_sel] = 1'b1;
        end
    end

    // Storage and scoreboard update; lane 1 is assigned last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (we0) begin
                regs_q[bus.wr_sel0] <= bus.wr_data0;
            end
            if (we1) begin
                regs_q[bus.wr_sel1] <= bus.wr_data1;
            end
            busy_q <= busy_d;
        end
    end

    assign bus.busy_any = |busy_q;
endmodule
